// File: rtl/axi_lite_pkg.sv
// Shared AXI-Lite response codes and FSM state encodings for the parametrised
// master and its timeout counter.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY    = 2'b00;
    localparam logic [1:0] RESP_EXOKAY  = 2'b01;
    localparam logic [1:0] RESP_SLVERR  = 2'b10;
    localparam logic [1:0] RESP_DECERR  = 2'b11;
    localparam logic [1:0] RESP_TIMEOUT = RESP_SLVERR;

    typedef enum logic [1:0] {W_IDLE, W_AD, W_RESP, W_DONE} wr_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_DONE} rd_state_t;

endpackage

// File: rtl/axi_lite_timeout_ctr.sv
// Saturating no-progress counter; expired marks the TO_CYC-th consecutive
// waiting cycle so the owning FSM can abort at the end of that cycle.
module axi_lite_timeout_ctr #(
    parameter int TO_W   = 8,
    parameter int TO_CYC = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [TO_W-1:0] LAST = (TO_CYC == 0) ? '0 : TO_W'(TO_CYC - 1);

    logic [TO_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && cnt != '1) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = (TO_CYC != 0) && en && (cnt == LAST);

endmodule

// File: rtl/axi_lite_master_param.sv
// AXI4-Lite master: independent write and read FSMs turning simple command
// handshakes into AXI-Lite transactions with per-phase timeout recovery.
module axi_lite_master_param
    import axi_lite_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int TO_W   = 8,
    parameter int TO_CYC = 255
) (
    input  logic                  m_axi_aclock,
    input  logic                  m_axi_areset,
    input  logic                  wr_cmd_valid,
    output logic                  wr_cmd_ready,
    input  logic [ADDR_W-1:0]     wr_cmd_addr,
    input  logic [DATA_W-1:0]     wr_cmd_data,
    input  logic [DATA_W/8-1:0]   wr_cmd_strb,
    output logic                  wr_done,
    output logic [1:0]            wr_resp,
    output logic                  wr_timeout,
    input  logic                  rd_cmd_valid,
    output logic                  rd_cmd_ready,
    input  logic [ADDR_W-1:0]     rd_cmd_addr,
    output logic                  rd_done,
    output logic [DATA_W-1:0]     rd_data,
    output logic [1:0]            rd_resp,
    output logic                  rd_timeout,
    output logic [ADDR_W-1:0]     m_axi_awaddr,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [DATA_W-1:0]     m_axi_wdata,
    output logic [DATA_W/8-1:0]   m_axi_wstrb,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    output logic [ADDR_W-1:0]     m_axi_araddr,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [DATA_W-1:0]     m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);

    wr_state_t  wr_state, wr_state_nxt;
    rd_state_t  rd_state, rd_state_nxt;
    logic       awvalid_nxt, wvalid_nxt, bready_nxt, wr_done_nxt, wr_timeout_nxt, wr_cmd_ready_nxt;
    logic       arvalid_nxt, rready_nxt, rd_done_nxt, rd_timeout_nxt, rd_cmd_ready_nxt;
    logic [1:0] wr_resp_nxt, rd_resp_nxt;
    logic       wr_accept, rd_accept, aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic       wr_wait, rd_wait, wr_clr, rd_clr, wr_expired, rd_expired;

    assign wr_accept = (wr_state == W_IDLE) && wr_cmd_valid && wr_cmd_ready;
    assign rd_accept = (rd_state == R_IDLE) && rd_cmd_valid && rd_cmd_ready;
    assign aw_hs     = m_axi_awvalid && m_axi_awready;
    assign w_hs      = m_axi_wvalid && m_axi_wready;
    assign b_hs      = m_axi_bready && m_axi_bvalid;
    assign ar_hs     = m_axi_arvalid && m_axi_arready;
    assign r_hs      = m_axi_rready && m_axi_rvalid;
    assign wr_wait   = (wr_state == W_AD) || (wr_state == W_RESP);
    assign rd_wait   = (rd_state == R_ADDR) || (rd_state == R_DATA);
    assign wr_clr    = !wr_wait || aw_hs || w_hs || b_hs;
    assign rd_clr    = !rd_wait || ar_hs || r_hs;

    axi_lite_timeout_ctr #(.TO_W(TO_W), .TO_CYC(TO_CYC)) u_wr_to (
        .clk(m_axi_aclock), .rst_n(m_axi_areset), .clr(wr_clr), .en(wr_wait), .expired(wr_expired)
    );

    axi_lite_timeout_ctr #(.TO_W(TO_W), .TO_CYC(TO_CYC)) u_rd_to (
        .clk(m_axi_aclock), .rst_n(m_axi_areset), .clr(rd_clr), .en(rd_wait), .expired(rd_expired)
    );

    // Outputs are registered from next-state values, so each pulse or valid
    // appears in the cycle its state is entered.
    always_comb begin
        wr_state_nxt   = wr_state;
        awvalid_nxt    = 1'b0;
        wvalid_nxt     = 1'b0;
        bready_nxt     = 1'b0;
        wr_done_nxt    = 1'b0;
        wr_resp_nxt    = wr_resp;
        wr_timeout_nxt = wr_timeout;
        case (wr_state)
            W_IDLE: begin
                if (wr_accept) begin
                    wr_state_nxt = W_AD;
                    awvalid_nxt  = 1'b1;
                    wvalid_nxt   = 1'b1;
                end
            end
            W_AD: begin
                awvalid_nxt = m_axi_awvalid && !m_axi_awready;
                wvalid_nxt  = m_axi_wvalid && !m_axi_wready;
                if (!awvalid_nxt && !wvalid_nxt) begin
                    wr_state_nxt = W_RESP;
                    bready_nxt   = 1'b1;
                end else if (wr_expired && !aw_hs && !w_hs) begin
                    awvalid_nxt    = 1'b0;
                    wvalid_nxt     = 1'b0;
                    wr_state_nxt   = W_DONE;
                    wr_done_nxt    = 1'b1;
                    wr_resp_nxt    = RESP_TIMEOUT;
                    wr_timeout_nxt = 1'b1;
                end
            end
            W_RESP: begin
                if (b_hs) begin
                    wr_state_nxt   = W_DONE;
                    wr_done_nxt    = 1'b1;
                    wr_resp_nxt    = m_axi_bresp;
                    wr_timeout_nxt = 1'b0;
                end else if (wr_expired) begin
                    wr_state_nxt   = W_DONE;
                    wr_done_nxt    = 1'b1;
                    wr_resp_nxt    = RESP_TIMEOUT;
                    wr_timeout_nxt = 1'b1;
                end else begin
                    bready_nxt = 1'b1;
                end
            end
            default: wr_state_nxt = W_IDLE;
        endcase
        wr_cmd_ready_nxt = (wr_state_nxt == W_IDLE);
    end

    always_comb begin
        rd_state_nxt   = rd_state;
        arvalid_nxt    = 1'b0;
        rready_nxt     = 1'b0;
        rd_done_nxt    = 1'b0;
        rd_resp_nxt    = rd_resp;
        rd_timeout_nxt = rd_timeout;
        case (rd_state)
            R_IDLE: begin
                if (rd_accept) begin
                    rd_state_nxt = R_ADDR;
                    arvalid_nxt  = 1'b1;
                end
            end
            R_ADDR: begin
                if (ar_hs) begin
                    rd_state_nxt = R_DATA;
                    rready_nxt   = 1'b1;
                end else if (rd_expired) begin
                    rd_state_nxt   = R_DONE;
                    rd_done_nxt    = 1'b1;
                    rd_resp_nxt    = RESP_TIMEOUT;
                    rd_timeout_nxt = 1'b1;
                end else begin
                    arvalid_nxt = 1'b1;
                end
            end
            R_DATA: begin
                if (r_hs) begin
                    rd_state_nxt   = R_DONE;
                    rd_done_nxt    = 1'b1;
                    rd_resp_nxt    = m_axi_rresp;
                    rd_timeout_nxt = 1'b0;
                end else if (rd_expired) begin
                    rd_state_nxt   = R_DONE;
                    rd_done_nxt    = 1'b1;
                    rd_resp_nxt    = RESP_TIMEOUT;
                    rd_timeout_nxt = 1'b1;
                end else begin
                    rready_nxt = 1'b1;
                end
            end
            default: rd_state_nxt = R_IDLE;
        endcase
        rd_cmd_ready_nxt = (rd_state_nxt == R_IDLE);
    end

    always_ff @(posedge m_axi_aclock or negedge m_axi_areset) begin
        if (!m_axi_areset) begin
            wr_state      <= W_IDLE;
            wr_cmd_ready  <= 1'b0;
            m_axi_awaddr  <= '0;
            m_axi_wdata   <= '0;
            m_axi_wstrb   <= '0;
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            wr_done       <= 1'b0;
            wr_resp       <= RESP_OKAY;
            wr_timeout    <= 1'b0;
        end else begin
            wr_state      <= wr_state_nxt;
            wr_cmd_ready  <= wr_cmd_ready_nxt;
            m_axi_awvalid <= awvalid_nxt;
            m_axi_wvalid  <= wvalid_nxt;
            m_axi_bready  <= bready_nxt;
            wr_done       <= wr_done_nxt;
            wr_resp       <= wr_resp_nxt;
            wr_timeout    <= wr_timeout_nxt;
            if (wr_accept) begin
                m_axi_awaddr <= wr_cmd_addr;
                m_axi_wdata  <= wr_cmd_data;
                m_axi_wstrb  <= wr_cmd_strb;
            end
        end
    end

    always_ff @(posedge m_axi_aclock or negedge m_axi_areset) begin
        if (!m_axi_areset) begin
            rd_state      <= R_IDLE;
            rd_cmd_ready  <= 1'b0;
            m_axi_araddr  <= '0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
            rd_done       <= 1'b0;
            rd_data       <= '0;
            rd_resp       <= RESP_OKAY;
            rd_timeout    <= 1'b0;
        end else begin
            rd_state      <= rd_state_nxt;
            rd_cmd_ready  <= rd_cmd_ready_nxt;
            m_axi_arvalid <= arvalid_nxt;
            m_axi_rready  <= rready_nxt;
            rd_done       <= rd_done_nxt;
            rd_resp       <= rd_resp_nxt;
            rd_timeout    <= rd_timeout_nxt;
            if (rd_accept) begin
                m_axi_araddr <= rd_cmd_addr;
            end
            if (r_hs) begin
                rd_data <= m_axi_rdata;
            end
        end
    end

endmodule

// File: tb/tb_axi_lite_master_param.sv
// Directed bench for axi_lite_master_param: a scripted AXI-Lite slave plus a
// transaction-level model predicting completion cycle, response and data.
module tb_axi_lite_master_param;
    import axi_lite_pkg::*;

    localparam int TO    = 15;
    localparam int NEVER = 1000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        wr_cmd_valid, wr_cmd_ready, wr_done, wr_timeout;
    logic [31:0] wr_cmd_addr, wr_cmd_data;
    logic [3:0]  wr_cmd_strb;
    logic [1:0]  wr_resp, rd_resp;
    logic        rd_cmd_valid, rd_cmd_ready, rd_done, rd_timeout;
    logic [31:0] rd_cmd_addr, rd_data;
    logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_awvalid, m_axi_awready = 1'b0, m_axi_wvalid, m_axi_wready = 1'b0;
    logic [1:0]  m_axi_bresp = 2'b00, m_axi_rresp = 2'b00;
    logic        m_axi_bvalid = 1'b0, m_axi_bready, m_axi_arvalid, m_axi_arready = 1'b0;
    logic [31:0] m_axi_rdata = '0;
    logic        m_axi_rvalid = 1'b0, m_axi_rready;

    axi_lite_master_param #(.ADDR_W(32), .DATA_W(32), .TO_W(8), .TO_CYC(TO)) dut (
        .m_axi_aclock(clk), .m_axi_areset(rst_n),
        .wr_cmd_valid(wr_cmd_valid), .wr_cmd_ready(wr_cmd_ready), .wr_cmd_addr(wr_cmd_addr),
        .wr_cmd_data(wr_cmd_data), .wr_cmd_strb(wr_cmd_strb), .wr_done(wr_done),
        .wr_resp(wr_resp), .wr_timeout(wr_timeout),
        .rd_cmd_valid(rd_cmd_valid), .rd_cmd_ready(rd_cmd_ready), .rd_cmd_addr(rd_cmd_addr),
        .rd_done(rd_done), .rd_data(rd_data), .rd_resp(rd_resp), .rd_timeout(rd_timeout),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
        .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    logic any_out;
    assign any_out = |{wr_cmd_ready, wr_done, wr_resp, wr_timeout, rd_cmd_ready, rd_done, rd_data,
                       rd_resp, rd_timeout, m_axi_awaddr, m_axi_awvalid, m_axi_wdata, m_axi_wstrb,
                       m_axi_wvalid, m_axi_bready, m_axi_araddr, m_axi_arvalid, m_axi_rready};

    // Slave script: latencies count cycles the master's valid/ready has been up.
    int          aw_lat = 0, w_lat = 0, b_lat = 0, ar_lat = 0, r_lat = 0;
    logic [1:0]  b_resp_s = 2'b00, r_resp_s = 2'b00;
    logic [31:0] r_data_s = '0;
    logic        spurious_b = 1'b0;
    int          aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;

    always @(posedge clk) begin
        #1;
        if (m_axi_awvalid) begin m_axi_awready = (aw_cnt == aw_lat); aw_cnt++; end
        else begin m_axi_awready = 1'b0; aw_cnt = 0; end
        if (m_axi_wvalid) begin m_axi_wready = (w_cnt == w_lat); w_cnt++; end
        else begin m_axi_wready = 1'b0; w_cnt = 0; end
        if (m_axi_arvalid) begin m_axi_arready = (ar_cnt == ar_lat); ar_cnt++; end
        else begin m_axi_arready = 1'b0; ar_cnt = 0; end
        if (m_axi_bready) begin
            m_axi_bvalid = (b_cnt >= b_lat); m_axi_bresp = b_resp_s; b_cnt++;
        end else begin
            m_axi_bvalid = spurious_b; m_axi_bresp = 2'b11; b_cnt = 0;
        end
        if (m_axi_rready) begin
            m_axi_rvalid = (r_cnt >= r_lat); m_axi_rdata = r_data_s; m_axi_rresp = r_resp_s; r_cnt++;
        end else begin
            m_axi_rvalid = 1'b0; m_axi_rdata = 32'h0BAD0BAD; r_cnt = 0;
        end
    end

    typedef struct {
        int          due;
        logic [1:0]  resp;
        logic        to;
        int          rdy_cyc;
        logic [31:0] data;
    } exp_t;

    exp_t wq[$];
    exp_t rq[$];

    // Completion cycle relative to the cycle the command handshake is seen.
    function automatic exp_t model_wr(input int n);
        exp_t e;
        int   m = (aw_lat > w_lat) ? aw_lat : w_lat;
        e.data = '0;
        if (b_lat >= TO) begin
            e.due = n + 2 + m + TO; e.resp = RESP_TIMEOUT; e.to = 1'b1; e.rdy_cyc = TO;
        end else begin
            e.due = n + 3 + m + b_lat; e.resp = b_resp_s; e.to = 1'b0; e.rdy_cyc = b_lat + 1;
        end
        return e;
    endfunction

    function automatic exp_t model_rd(input int n);
        exp_t e;
        e.data = r_data_s; e.resp = r_resp_s; e.to = 1'b0;
        if (ar_lat >= TO) begin
            e.due = n + 1 + TO; e.resp = RESP_TIMEOUT; e.to = 1'b1; e.rdy_cyc = 0;
        end else if (r_lat >= TO) begin
            e.due = n + 2 + ar_lat + TO; e.resp = RESP_TIMEOUT; e.to = 1'b1; e.rdy_cyc = TO;
        end else begin
            e.due = n + 3 + ar_lat + r_lat; e.rdy_cyc = r_lat + 1;
        end
        return e;
    endfunction

    logic        wr_busy = 1'b0, rd_busy = 1'b0;
    logic [31:0] exp_rd_data = '0, cur_awaddr = '0, cur_wdata = '0, cur_araddr = '0;
    logic [3:0]  cur_wstrb = '0;
    int          aw_hs_n = 0, w_hs_n = 0, ar_hs_n = 0, aw_vcyc = 0, w_vcyc = 0, b_rdy_n = 0, r_rdy_n = 0;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            chk("reset_outputs_zero", any_out, 1'b0);
            wq.delete(); rq.delete();
            wr_busy = 1'b0; rd_busy = 1'b0; exp_rd_data = '0;
        end else begin
            chk("wr_cmd_ready", wr_cmd_ready, !wr_busy);
            chk("rd_cmd_ready", rd_cmd_ready, !rd_busy);
            if (m_axi_awvalid) aw_vcyc++;
            if (m_axi_wvalid) w_vcyc++;
            if (m_axi_bready) begin
                b_rdy_n++;
                chk("bready_after_aw_and_w", (aw_hs_n == 1) && (w_hs_n == 1), 1'b1);
            end
            if (m_axi_rready) begin
                r_rdy_n++;
                chk("rready_after_ar", ar_hs_n == 1, 1'b1);
            end
            if (m_axi_awvalid && m_axi_awready) begin
                aw_hs_n++; chk("awaddr", m_axi_awaddr, cur_awaddr);
            end
            if (m_axi_wvalid && m_axi_wready) begin
                w_hs_n++; chk("wdata", m_axi_wdata, cur_wdata); chk("wstrb", m_axi_wstrb, cur_wstrb);
            end
            if (m_axi_arvalid && m_axi_arready) begin
                ar_hs_n++; chk("araddr", m_axi_araddr, cur_araddr);
            end

            if (wr_done) begin
                if (wq.size() == 0) begin
                    chk("wr_done_unexpected", wr_done, 1'b0);
                end else begin
                    e = wq.pop_front();
                    chk("wr_done_cycle", cyc, e.due);
                    chk("wr_resp", wr_resp, e.resp);
                    chk("wr_timeout", wr_timeout, e.to);
                    chk("bready_cycles", b_rdy_n, e.rdy_cyc);
                    chk("bready_low_at_done", m_axi_bready, 1'b0);
                    if (!e.to) begin
                        chk("aw_handshakes", aw_hs_n, 1);
                        chk("w_handshakes", w_hs_n, 1);
                    end
                end
                wr_busy = 1'b0;
            end else if (wq.size() > 0 && wq[0].due == cyc) begin
                chk("wr_done_missing", wr_done, 1'b1);
                void'(wq.pop_front());
                wr_busy = 1'b0;
            end

            if (rd_done) begin
                if (rq.size() == 0) begin
                    chk("rd_done_unexpected", rd_done, 1'b0);
                end else begin
                    e = rq.pop_front();
                    chk("rd_done_cycle", cyc, e.due);
                    chk("rd_resp", rd_resp, e.resp);
                    chk("rd_timeout", rd_timeout, e.to);
                    chk("rready_cycles", r_rdy_n, e.rdy_cyc);
                    if (!e.to) exp_rd_data = e.data;
                end
                rd_busy = 1'b0;
            end else if (rq.size() > 0 && rq[0].due == cyc) begin
                chk("rd_done_missing", rd_done, 1'b1);
                void'(rq.pop_front());
                rd_busy = 1'b0;
            end
            chk("rd_data_held", rd_data, exp_rd_data);

            if (wr_cmd_valid && wr_cmd_ready) begin
                wq.push_back(model_wr(cyc));
                wr_busy = 1'b1;
                cur_awaddr = wr_cmd_addr; cur_wdata = wr_cmd_data; cur_wstrb = wr_cmd_strb;
                aw_hs_n = 0; w_hs_n = 0; aw_vcyc = 0; w_vcyc = 0; b_rdy_n = 0;
            end
            if (rd_cmd_valid && rd_cmd_ready) begin
                rq.push_back(model_rd(cyc));
                rd_busy = 1'b1;
                cur_araddr = rd_cmd_addr;
                ar_hs_n = 0; r_rdy_n = 0;
            end
        end
    end

    task automatic start_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, output int acc);
        acc = -1;
        @(posedge clk); #1;
        wr_cmd_valid = 1'b1; wr_cmd_addr = a; wr_cmd_data = d; wr_cmd_strb = s;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (wr_cmd_ready) begin acc = cyc; break; end
        end
        if (acc < 0) chk("wr_cmd_accept_bound", 1'b0, 1'b1);
        @(posedge clk); #1;
        wr_cmd_valid = 1'b0;
    endtask

    task automatic start_rd(input logic [31:0] a, output int acc);
        acc = -1;
        @(posedge clk); #1;
        rd_cmd_valid = 1'b1; rd_cmd_addr = a;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rd_cmd_ready) begin acc = cyc; break; end
        end
        if (acc < 0) chk("rd_cmd_accept_bound", 1'b0, 1'b1);
        @(posedge clk); #1;
        rd_cmd_valid = 1'b0;
    endtask

    task automatic wait_wr(output int dn);
        dn = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (wr_done) begin dn = cyc; break; end
        end
        if (dn < 0) chk("wr_done_bound", 1'b0, 1'b1);
    endtask

    task automatic wait_rd(output int dn);
        dn = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rd_done) begin dn = cyc; break; end
        end
        if (dn < 0) chk("rd_done_bound", 1'b0, 1'b1);
    endtask

    initial begin
        int wacc, wdn, racc, rdn;
        wr_cmd_valid = 1'b0; wr_cmd_addr = '0; wr_cmd_data = '0; wr_cmd_strb = '0;
        rd_cmd_valid = 1'b0; rd_cmd_addr = '0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("wr_ready_first_clock", wr_cmd_ready, 1'b1);
        chk("rd_ready_first_clock", rd_cmd_ready, 1'b1);

        aw_lat = 0; w_lat = 0; b_lat = 0; b_resp_s = RESP_OKAY;
        start_wr(32'h10, 32'hA5A5A5A5, 4'hF, wacc); wait_wr(wdn);
        chk("zero_wait_wr_latency", wdn - wacc, 3);

        aw_lat = 2; w_lat = 6; b_lat = 0; b_resp_s = RESP_DECERR;
        start_wr(32'h24, 32'h0000BEEF, 4'h3, wacc); wait_wr(wdn);
        chk("split_wr_latency", wdn - wacc, 9);
        @(posedge clk); #1;
        chk("split_awvalid_cycles", aw_vcyc, 3);
        chk("split_wvalid_cycles", w_vcyc, 7);

        ar_lat = 3; r_lat = 0; r_data_s = 32'hDEADBEEF; r_resp_s = RESP_SLVERR;
        start_rd(32'h100, racc); wait_rd(rdn);
        chk("slverr_rd_latency", rdn - racc, 6);
        chk("slverr_rd_data", rd_data, 32'hDEADBEEF);

        ar_lat = 0; r_lat = 2; r_data_s = 32'h12345678; r_resp_s = RESP_EXOKAY;
        start_rd(32'h104, racc); wait_rd(rdn);
        chk("exokay_rd_latency", rdn - racc, 5);

        ar_lat = 0; r_lat = NEVER; r_data_s = 32'hFFFF0000;
        start_rd(32'h108, racc); wait_rd(rdn);
        chk("rd_timeout_latency", rdn - racc, 17);
        chk("rd_timeout_resp", rd_resp, 2'b10);
        chk("rd_timeout_data_held", rd_data, 32'h12345678);

        aw_lat = 0; w_lat = 0; b_lat = NEVER;
        start_wr(32'h200, 32'h11112222, 4'hF, wacc); wait_wr(wdn);
        chk("wr_timeout_latency", wdn - wacc, 17);
        chk("wr_timeout_flag", wr_timeout, 1'b1);
        @(posedge clk); #1;
        chk("wr_timeout_bready_cycles", b_rdy_n, 15);
        @(negedge clk);
        chk("wr_idle_after_timeout", wr_cmd_ready, 1'b1);

        b_lat = TO - 1; b_resp_s = RESP_EXOKAY;
        start_wr(32'h204, 32'h33334444, 4'h8, wacc); wait_wr(wdn);
        chk("wr_last_cycle_bvalid_latency", wdn - wacc, 17);
        chk("wr_last_cycle_bvalid_resp", wr_resp, 2'b01);

        spurious_b = 1'b1;
        repeat (5) @(posedge clk);
        #1 spurious_b = 1'b0;

        aw_lat = 1; w_lat = 0; b_lat = NEVER;
        ar_lat = 0; r_lat = 1; r_data_s = 32'hCAFEF00D; r_resp_s = RESP_OKAY;
        fork
            start_wr(32'h300, 32'h55556666, 4'hF, wacc);
            start_rd(32'h304, racc);
        join
        chk("concurrent_same_cycle_accept", racc - wacc, 0);
        fork
            wait_wr(wdn);
            wait_rd(rdn);
        join
        chk("concurrent_rd_latency", rdn - racc, 4);
        chk("concurrent_wr_timeout_latency", wdn - wacc, 18);

        ar_lat = 0; r_lat = NEVER;
        start_rd(32'h400, racc);
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk("async_reset_outputs", any_out, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rd_ready_after_reset", rd_cmd_ready, 1'b1);
        chk("rd_data_after_reset", rd_data, 32'h0);

        r_lat = 0; r_data_s = 32'h0F0F0F0F; r_resp_s = RESP_DECERR;
        start_rd(32'h500, racc); wait_rd(rdn);
        chk("post_reset_rd_latency", rdn - racc, 3);
        chk("post_reset_rd_resp", rd_resp, 2'b11);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000, expected finish earlier");
        $fatal(1, "watchdog expired");
    end

endmodule
